// File: rtl/printf_uart_pkg.sv
// Shared constants and FSM encoding for the printf UART transmitter.
// Build option: PRINTF_UART_TX_PARITY_EN selects 8E1 framing instead of 8N1.
package printf_uart_pkg;

    localparam int unsigned DataBits   = 8;
    localparam logic [2:0]  LastBitIdx = 3'(DataBits - 1);
    localparam logic        IdleLevel  = 1'b1;
    localparam logic        StartLevel = 1'b0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3
`ifdef PRINTF_UART_TX_PARITY_EN
        ,
        StParity = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/printf_tx_fifo.sv
// Byte FIFO feeding the serializer: synchronous, registered occupancy count.
// Push is refused while full, even if a pop happens in the same cycle.
module printf_tx_fifo
    import printf_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rstp,
    input  logic                        push,
    input  logic [DataBits-1:0]         push_data,
    output logic                        full,
    input  logic                        pop,
    output logic [DataBits-1:0]         head,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [DataBits-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]     wptr;
    logic [PtrW-1:0]     rptr;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count == (PtrW + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rptr];

    // Pointers are exactly PtrW bits wide so they wrap modulo the depth.
    always_ff @(posedge clk) begin
        if (rstp) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/printf_uart_tx.sv
// Buffered UART transmitter for printf-style debug output (8N1 by default).
// Build option: PRINTF_UART_TX_PARITY_EN adds an even-parity bit (8E1).
module printf_uart_tx
    import printf_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned BAUD_DIV_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rstp,
    input  logic [BAUD_DIV_WIDTH-1:0]   baud_div,
    input  logic                        wvalid,
    input  logic [7:0]                  wdata,
    output logic                        wready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        printf_tx
);

    tx_state_e                 state;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic [DataBits-1:0]       head;
    logic [BAUD_DIV_WIDTH-1:0] div_q;
    logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
    logic [2:0]                bit_idx;
    logic [DataBits-1:0]       shreg;
    logic                      tail_q;
    logic                      bit_done;
`ifdef PRINTF_UART_TX_PARITY_EN
    logic                      par_q;
`endif

    printf_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstp      (rstp),
        .push      (wvalid),
        .push_data (wdata),
        .full      (fifo_full),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_done = (baud_cnt == div_q);
    assign pop      = !fifo_empty && ((state == StIdle) || (state == StStop && bit_done));
    assign wready   = !fifo_full;
    // tail_q covers the final stop-bit cycle, which the line shows one cycle after the state.
    assign busy     = tail_q || (state != StIdle) || (fifo_count != '0);

    // The line is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rstp) begin
            state     <= StIdle;
            printf_tx <= IdleLevel;
            div_q     <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tail_q    <= 1'b0;
`ifdef PRINTF_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            tail_q   <= (state != StIdle);
            baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            unique case (state)
                StIdle: begin
                    printf_tx <= IdleLevel;
                    baud_cnt  <= '0;
                    if (pop) begin
                        shreg   <= head;
                        div_q   <= baud_div;
                        bit_idx <= '0;
`ifdef PRINTF_UART_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                        state   <= StStart;
                    end
                end
                StStart: begin
                    printf_tx <= StartLevel;
                    if (bit_done) state <= StData;
                end
                StData: begin
                    printf_tx <= shreg[0];
                    if (bit_done) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LastBitIdx) begin
`ifdef PRINTF_UART_TX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
`ifdef PRINTF_UART_TX_PARITY_EN
                StParity: begin
                    printf_tx <= par_q;
                    if (bit_done) state <= StStop;
                end
`endif
                StStop: begin
                    printf_tx <= IdleLevel;
                    if (bit_done) begin
                        // Back-to-back frames: reload straight into START with no idle gap.
                        if (pop) begin
                            shreg   <= head;
                            div_q   <= baud_div;
                            bit_idx <= '0;
`ifdef PRINTF_UART_TX_PARITY_EN
                            par_q   <= ^head;
`endif
                            state   <= StStart;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_printf_uart_tx.sv
// Self-checking bench for printf_uart_tx: vector table, directed corner cases,
// random traffic checked by a frame-level serial-line monitor.
module tb_printf_uart_tx;

    localparam int unsigned DEPTH = 16;
`ifdef PRINTF_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rstp = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        wvalid = 1'b0;
    logic [7:0]  wdata = 8'd0;
    logic        wready;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        printf_tx;

    printf_uart_tx #(
        .FIFO_DEPTH     (DEPTH),
        .BAUD_DIV_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rstp       (rstp),
        .baud_div   (baud_div),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .wready     (wready),
        .busy       (busy),
        .fifo_count (fifo_count),
        .printf_tx  (printf_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame-level line monitor: every frame must match the next expected byte with
    // each bit lasting (baud_div at pop time)+1 cycles; pop happens one edge before the fall.
    logic        rst_d = 1'b1;
    logic [15:0] div_d1 = '0;
    logic [15:0] div_d2 = '0;
    logic        prev_tx = 1'b1;
    logic        mon_active = 1'b0;
    logic        mon_bad;
    logic [10:0] mon_bits;
    int          mon_pos, mon_per;
    int          cyc = 0;
    int          last_start = 0;
    int          last_end = 0;
    int          frames_done = 0;

    always @(posedge clk) begin
        rst_d  <= rstp;
        div_d1 <= baud_div;
        div_d2 <= div_d1;
    end

    always @(negedge clk) begin
        logic [7:0] b;
        logic       in_frame;
        cyc++;
        in_frame = mon_active;
        if (rst_d) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && prev_tx && !printf_tx) begin
                check("start_has_data", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    mon_bits = '1;
                    mon_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) mon_bits[i+1] = b[i];
                    if (NB == 11) mon_bits[9] = ^b;
                    mon_bits[NB-1] = 1'b1;
                    mon_per    = int'(div_d2) + 1;
                    mon_pos    = 0;
                    mon_bad    = 1'b0;
                    mon_active = 1'b1;
                    in_frame   = 1'b1;
                    last_start = cyc;
                end
            end
            if (mon_active) begin
                if (printf_tx != mon_bits[mon_pos / mon_per]) mon_bad = 1'b1;
                mon_pos++;
                if (mon_pos == NB * mon_per) begin
                    check("frame_match", int'(mon_bad), 0);
                    frames_done++;
                    last_end   = cyc;
                    mon_active = 1'b0;
                end
            end
            check("wready_inv", wready, int'(fifo_count != 5'(DEPTH)));
            check("busy_inv", int'(busy || !(in_frame || fifo_count != 0)), 1);
        end
        prev_tx = printf_tx;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rstp   = 1'b1;
        wvalid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstp = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        wvalid = 1'b1;
        wdata  = b;
        while (!wready && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("push_ready", wready, 1);
        if (wready) exp_q.push_back(b);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int t = 0;
        while ((exp_q.size() != 0 || mon_active) && t < bound) begin
            @(negedge clk); #1;
            t++;
        end
        check(name, exp_q.size() + int'(mon_active), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [9:0] frame;  // bit i = i-th bit on the line for 8N1 (start, d0..d7, stop)
        logic       par;
    } vec_t;

    task automatic run_vector(input vec_t v);
        logic samp [128];
        int   p;
        int   expb;
        p = v.div + 1;
        do_reset();
        baud_div = 16'(v.div);
        @(posedge clk); #1;
        push_byte(v.data);
        @(negedge clk);
        check("lat_count1", fifo_count, 1);
        check("lat_tx_e0", printf_tx, 1);
        @(negedge clk);
        check("lat_count0", fifo_count, 0);
        check("lat_tx_e1", printf_tx, 1);
        for (int c = 0; c < NB * p; c++) begin
            @(negedge clk);
            samp[c] = printf_tx;
            if (c == NB * p - 1) check("busy_last_stop", busy, 1);
        end
        for (int k = 0; k < NB; k++) begin
            if (k == NB - 1)  expb = int'(v.frame[9]);
            else if (k == 9)  expb = int'(v.par);
            else              expb = int'(v.frame[k]);
            check($sformatf("vec_%02h_bit%0d", v.data, k), int'(samp[k * p + p / 2]), expb);
        end
        check("start_first_cycle", int'(samp[0]), 0);
        @(negedge clk);
        check("busy_after_stop", busy, 0);
        check("idle_after_stop", printf_tx, 1);
        @(posedge clk); #1;
    endtask

    vec_t vecs [7];

    initial begin
        int s0, f0, t, lows;

        vecs[0] = '{data: 8'h55, div: 3, frame: 10'h2AA, par: 1'b0};
        vecs[1] = '{data: 8'hA3, div: 0, frame: 10'h346, par: 1'b0};
        vecs[2] = '{data: 8'h00, div: 1, frame: 10'h200, par: 1'b0};
        vecs[3] = '{data: 8'hFF, div: 2, frame: 10'h3FE, par: 1'b0};
        vecs[4] = '{data: 8'h01, div: 4, frame: 10'h202, par: 1'b1};
        vecs[5] = '{data: 8'h80, div: 0, frame: 10'h300, par: 1'b1};
        vecs[6] = '{data: 8'h3C, div: 5, frame: 10'h278, par: 1'b0};

        do_reset();
        @(negedge clk);
        check("rst_tx", printf_tx, 1);
        check("rst_count", fifo_count, 0);
        check("rst_wready", wready, 1);
        check("rst_busy", busy, 0);

        foreach (vecs[i]) run_vector(vecs[i]);

        // Burst: 17 bytes fill the buffer with one in flight, an 18th waits for a pop.
        do_reset();
        baud_div = 16'd1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) push_byte(8'(8'h30 + i));
        s0 = last_start;
        wvalid = 1'b1;
        wdata  = 8'h41;
        @(negedge clk);
        check("burst_full_count", fifo_count, 16);
        check("burst_full_wready", wready, 0);
        t = 0;
        while (fifo_count == 5'd16 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_at_full_with_pop", fifo_count, 15);
        @(posedge clk); #1;
        wvalid = 1'b0;
        exp_q.push_back(8'h41);
        @(negedge clk);
        check("held_byte_accepted", fifo_count, 16);
        wait_drain("burst_drain", 2000);
        check("burst_gapless_span", last_end - s0 + 1, 18 * NB * 2);

        // baud_div change mid-frame applies only to the following frame.
        do_reset();
        baud_div = 16'd3;
        @(posedge clk); #1;
        f0 = frames_done;
        push_byte(8'h5A);
        push_byte(8'hC3);
        t = 0;
        while (!mon_active && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        check("chg_frame_started", int'(mon_active), 1);
        repeat (12) @(posedge clk);
        #1;
        baud_div = 16'd7;
        wait_drain("chg_drain", 500);
        check("chg_frames", frames_done - f0, 2);
        check("chg_frame2_len", last_end - last_start + 1, NB * 8);

        // Reset in the middle of a frame with bytes queued.
        do_reset();
        baud_div = 16'd3;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push_byte(8'(8'hE0 + i));
        t = 0;
        while (!(mon_active && mon_pos >= 21) && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check("mid_reached_bit4", int'(mon_active && mon_pos >= 21), 1);
        check("mid_queued", fifo_count, 5);
        @(posedge clk); #1;
        rstp = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rstp = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", printf_tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wready", wready, 1);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!printf_tx) lows++;
        end
        check("mid_no_restart", lows, 0);
        @(posedge clk); #1;

        // Random traffic with occasional baud changes.
        do_reset();
        baud_div = 16'd0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 2));
            wvalid = ($urandom_range(0, 2) == 0);
            wdata  = 8'($urandom);
            if (wvalid && wready) exp_q.push_back(wdata);
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
        wait_drain("rand_drain", 20000);
        @(negedge clk);
        check("rand_end_busy", busy, 0);
        check("rand_end_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
